// File: rtl/uart_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_arbiter
// Purpose  : Round-robin arbiter / sequencer sharing one UART command engine
//            among NUM_REQ requesters. One command in flight at a time; the
//            engine's ready/busy handshake is tracked to completion, then a
//            one-cycle response (completion or read data) is returned to the
//            granted requester. A cycle timeout guards against a hung engine.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            req_vld/req_cmd     - per-requester valid and packed commands
//            req_rdy             - one-hot pulse, command accepted by engine
//            rsp_vld/data/err    - one-hot completion pulse with read data
//            busy, grant_id      - sequencer status
//            uart_cmd_*          - command handshake to the engine
//            uart_read_*         - read-data pulse from the engine
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int CMD_WIDTH  = 16,
    parameter int READ_WIDTH = 8,
    parameter int TIMEOUT    = 50000,
    parameter int IDW        = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_vld,
    input  logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd,
    output logic [NUM_REQ-1:0]           req_rdy,
    output logic [NUM_REQ-1:0]           rsp_vld,
    output logic [READ_WIDTH-1:0]        rsp_data,
    output logic                         rsp_err,
    output logic                         busy,
    output logic [IDW-1:0]               grant_id,
    output logic [CMD_WIDTH-1:0]         uart_cmd_in,
    output logic                         uart_cmd_vld,
    input  logic                         uart_cmd_rdy,
    input  logic                         uart_read_rdy,
    input  logic [READ_WIDTH-1:0]        uart_read_data
);

    localparam int                 c_CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [IDW-1:0]     c_LAST_RST = IDW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RESP      = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t                 r_state_q,    w_state_d;
    logic [IDW-1:0]         r_grant_q,    w_grant_d;
    logic [IDW-1:0]         r_last_q,     w_last_d;
    logic [CMD_WIDTH-1:0]   r_cmd_q,      w_cmd_d;
    logic [READ_WIDTH-1:0]  r_rd_q,       w_rd_d;
    logic                   r_got_q,      w_got_d;
    logic [c_CNT_W-1:0]     r_cnt_q,      w_cnt_d;
    logic                   r_cmd_vld_q,  w_cmd_vld_d;
    logic [CMD_WIDTH-1:0]   r_cmd_in_q,   w_cmd_in_d;
    logic [NUM_REQ-1:0]     r_rsp_vld_q,  w_rsp_vld_d;
    logic [READ_WIDTH-1:0]  r_rsp_data_q, w_rsp_data_d;
    logic                   r_rsp_err_q,  w_rsp_err_d;

    // ------------------------------------------------------------------------
    // Unpack the command bus so it can be indexed by a grant number
    // ------------------------------------------------------------------------
    logic [CMD_WIDTH-1:0] w_cmd_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_cmd_arr[gi] = req_cmd[gi*CMD_WIDTH +: CMD_WIDTH];
    end

    // ------------------------------------------------------------------------
    // Round-robin pick: first set request searching last+1, last+2, ...
    // Scanning from the farthest distance down to 1 lets the nearest win.
    // ------------------------------------------------------------------------
    logic [IDW-1:0] w_pick;
    logic [IDW-1:0] w_idx;
    logic           w_any;

    always_comb begin
        w_pick = r_last_q;
        w_idx  = r_last_q;
        w_any  = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = IDW'((int'(r_last_q) + k) % NUM_REQ);
            if (req_vld[w_idx]) begin
                w_pick = w_idx;
                w_any  = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    logic [NUM_REQ-1:0]    w_grant_oh;
    logic [c_CNT_W-1:0]    w_cnt_inc;
    logic                  w_timeout;
    logic                  w_go_resp;
    logic                  w_to_err;
    logic [READ_WIDTH-1:0] w_rd_now;
    logic                  w_got_now;

    assign w_grant_oh = NUM_REQ'(1) << r_grant_q;
    assign w_cnt_inc  = r_cnt_q + 1'b1;
    // The counter reaching TIMEOUT-1 lands RESP exactly TIMEOUT cycles
    // after the accepting cycle.
    assign w_timeout  = (w_cnt_inc == c_CNT_LAST);

    always_comb begin
        w_state_d    = r_state_q;
        w_grant_d    = r_grant_q;
        w_last_d     = r_last_q;
        w_cmd_d      = r_cmd_q;
        w_rd_d       = r_rd_q;
        w_got_d      = r_got_q;
        w_cnt_d      = r_cnt_q;
        w_cmd_vld_d  = 1'b0;
        w_cmd_in_d   = '0;
        w_rsp_vld_d  = '0;
        w_rsp_data_d = '0;
        w_rsp_err_d  = 1'b0;
        w_go_resp    = 1'b0;
        w_to_err     = 1'b0;
        w_rd_now     = r_rd_q;
        w_got_now    = r_got_q;
        req_rdy      = '0;

        case (r_state_q)
            S_IDLE: begin
                if (w_any) begin
                    w_grant_d   = w_pick;
                    w_cmd_d     = w_cmd_arr[w_pick];
                    w_cmd_vld_d = 1'b1;
                    w_cmd_in_d  = w_cmd_arr[w_pick];
                    w_state_d   = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // uart_cmd_vld is high throughout ISSUE, so a ready engine
                // accepts regardless of a late withdrawal. req_rdy has to be
                // combinational on uart_cmd_rdy to pulse in the accept cycle.
                if (uart_cmd_rdy) begin
                    req_rdy   = w_grant_oh;
                    w_last_d  = r_grant_q;
                    w_cnt_d   = '0;
                    w_rd_d    = '0;
                    w_got_d   = 1'b0;
                    w_state_d = S_WAIT_BUSY;
                end else if (!req_vld[r_grant_q]) begin
                    w_state_d = S_IDLE;
                end else begin
                    w_cmd_vld_d = 1'b1;
                    w_cmd_in_d  = r_cmd_q;
                end
            end

            S_WAIT_BUSY: begin
                w_cnt_d = w_cnt_inc;
                if (w_timeout) begin
                    w_go_resp = 1'b1;
                    w_to_err  = 1'b1;
                end else if (!uart_cmd_rdy) begin
                    w_state_d = S_WAIT_DONE;
                end
            end

            S_WAIT_DONE: begin
                w_cnt_d = w_cnt_inc;
                // Data arriving in the completion cycle must still be
                // reflected in the response being built now.
                if (uart_read_rdy) begin
                    w_rd_now  = uart_read_data;
                    w_got_now = 1'b1;
                end
                w_rd_d  = w_rd_now;
                w_got_d = w_got_now;
                if (uart_cmd_rdy) begin
                    w_go_resp = 1'b1;          // completion beats timeout
                end else if (w_timeout) begin
                    w_go_resp = 1'b1;
                    w_to_err  = 1'b1;
                end
            end

            S_RESP: begin
                w_got_d   = 1'b0;
                w_state_d = S_IDLE;
            end

            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        if (w_go_resp) begin
            w_state_d   = S_RESP;
            w_rsp_vld_d = w_grant_oh;
            if (r_cmd_q[CMD_WIDTH-1]) begin
                w_rsp_data_d = '0;
                w_rsp_err_d  = w_to_err;
            end else begin
                w_rsp_data_d = w_rd_now;
                w_rsp_err_d  = ~w_got_now | w_to_err;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= S_IDLE;
            r_grant_q    <= '0;
            r_last_q     <= c_LAST_RST;
            r_cmd_q      <= '0;
            r_rd_q       <= '0;
            r_got_q      <= 1'b0;
            r_cnt_q      <= '0;
            r_cmd_vld_q  <= 1'b0;
            r_cmd_in_q   <= '0;
            r_rsp_vld_q  <= '0;
            r_rsp_data_q <= '0;
            r_rsp_err_q  <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_grant_q    <= w_grant_d;
            r_last_q     <= w_last_d;
            r_cmd_q      <= w_cmd_d;
            r_rd_q       <= w_rd_d;
            r_got_q      <= w_got_d;
            r_cnt_q      <= w_cnt_d;
            r_cmd_vld_q  <= w_cmd_vld_d;
            r_cmd_in_q   <= w_cmd_in_d;
            r_rsp_vld_q  <= w_rsp_vld_d;
            r_rsp_data_q <= w_rsp_data_d;
            r_rsp_err_q  <= w_rsp_err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rsp_vld      = r_rsp_vld_q;
    assign rsp_data     = r_rsp_data_q;
    assign rsp_err      = r_rsp_err_q;
    assign busy         = (r_state_q != S_IDLE);
    assign grant_id     = r_grant_q;
    assign uart_cmd_in  = r_cmd_in_q;
    assign uart_cmd_vld = r_cmd_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_arbiter
// Purpose  : Directed self-checking bench for uart_cmd_arbiter; the bench
//            plays the UART engine and the requesters cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int CMD_WIDTH  = 16;
    localparam int READ_WIDTH = 8;
    localparam int TIMEOUT    = 100;
    localparam int IDW        = 2;

    logic                         clk;
    logic                         rst;
    logic [NUM_REQ-1:0]           req_vld;
    logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd;
    logic [NUM_REQ-1:0]           req_rdy;
    logic [NUM_REQ-1:0]           rsp_vld;
    logic [READ_WIDTH-1:0]        rsp_data;
    logic                         rsp_err;
    logic                         busy;
    logic [IDW-1:0]               grant_id;
    logic [CMD_WIDTH-1:0]         uart_cmd_in;
    logic                         uart_cmd_vld;
    logic                         uart_cmd_rdy;
    logic                         uart_read_rdy;
    logic [READ_WIDTH-1:0]        uart_read_data;

    int n_cmp = 0;
    int n_err = 0;

    uart_cmd_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .CMD_WIDTH (CMD_WIDTH),
        .READ_WIDTH(READ_WIDTH),
        .TIMEOUT   (TIMEOUT),
        .IDW       (IDW)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .req_vld       (req_vld),
        .req_cmd       (req_cmd),
        .req_rdy       (req_rdy),
        .rsp_vld       (rsp_vld),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .busy          (busy),
        .grant_id      (grant_id),
        .uart_cmd_in   (uart_cmd_in),
        .uart_cmd_vld  (uart_cmd_vld),
        .uart_cmd_rdy  (uart_cmd_rdy),
        .uart_read_rdy (uart_read_rdy),
        .uart_read_data(uart_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        req_vld       = '0;
        uart_read_rdy = 1'b0;
        uart_cmd_rdy  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_cmd(input int id, input logic [15:0] cmd);
        req_cmd[id*CMD_WIDTH +: CMD_WIDTH] = cmd;
        req_vld[id] = 1'b1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},    32'(busy),         32'd0);
        check({tag, "_cmdvld"},  32'(uart_cmd_vld), 32'd0);
        check({tag, "_cmdin"},   32'(uart_cmd_in),  32'd0);
        check({tag, "_rspvld"},  32'(rsp_vld),      32'd0);
        check({tag, "_reqrdy"},  32'(req_rdy),      32'd0);
        check({tag, "_rspdata"}, 32'(rsp_data),     32'd0);
        check({tag, "_rsperr"},  32'(rsp_err),      32'd0);
        check({tag, "_grant"},   32'(grant_id),     32'd0);
    endtask

    // One full transaction starting in IDLE with the request already driven
    // and the engine idle.
    task automatic txn(input string tag, input int id, input logic [15:0] cmd,
                       input bit drop, input bit rd_pulse, input logic [7:0] rdata,
                       input bit exp_err, input logic [7:0] exp_data);
        tick();                                        // ISSUE
        check({tag, "_cmdvld"}, 32'(uart_cmd_vld), 32'd1);
        check({tag, "_cmdin"},  32'(uart_cmd_in),  32'(cmd));
        check({tag, "_reqrdy"}, 32'(req_rdy),      32'd1 << id);
        check({tag, "_grant"},  32'(grant_id),     32'(id));
        tick();                                        // WAIT_BUSY
        if (drop) req_vld[id] = 1'b0;
        uart_cmd_rdy = 1'b0;
        check({tag, "_rdy1cyc"}, 32'(req_rdy),      32'd0);
        check({tag, "_vldoff"},  32'(uart_cmd_vld), 32'd0);
        tick();                                        // WAIT_DONE
        if (rd_pulse) begin
            uart_read_rdy  = 1'b1;
            uart_read_data = rdata;
            tick();
            uart_read_rdy  = 1'b0;
        end
        uart_cmd_rdy = 1'b1;
        tick();                                        // RESP
        check({tag, "_rspvld"},  32'(rsp_vld),  32'd1 << id);
        check({tag, "_rspdata"}, 32'(rsp_data), 32'(exp_data));
        check({tag, "_rsperr"},  32'(rsp_err),  32'(exp_err));
        tick();                                        // IDLE
        check({tag, "_rsp1cyc"}, 32'(rsp_vld), 32'd0);
    endtask

    initial begin
        int n;
        logic [NUM_REQ-1:0] seen;
        rst            = 1'b1;
        req_vld        = '0;
        req_cmd        = '0;
        uart_cmd_rdy   = 1'b1;
        uart_read_rdy  = 1'b0;
        uart_read_data = '0;

        // Reset state
        do_reset();
        check_idle_outputs("rst");

        // 1: write from requester 0
        set_cmd(0, 16'h8A55);
        txn("t1", 0, 16'h8A55, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        check("t1_busy_end", 32'(busy), 32'd0);

        // 2: read from requester 2 with data
        set_cmd(2, 16'h0031);
        txn("t2", 2, 16'h0031, 1'b1, 1'b1, 8'hC3, 1'b0, 8'hC3);

        // 5: read completing without data (stale C3 must not leak)
        set_cmd(3, 16'h0044);
        txn("t5", 3, 16'h0044, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00);

        // 3: all requesters held -> 0,1,2,3,0
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_cmd(i, 16'h8000 | 16'(i));
        txn("t3a", 0, 16'h8000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        txn("t3b", 1, 16'h8001, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        txn("t3c", 2, 16'h8002, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        txn("t3d", 3, 16'h8003, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        txn("t3e", 0, 16'h8000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        req_vld = '0;

        // 4: read timeout, engine stays busy (last = 0, so requester 1 wins)
        set_cmd(1, 16'h0012);
        tick();                                        // ISSUE
        check("t4_reqrdy", 32'(req_rdy), 32'b0010);
        tick();                                        // WAIT_BUSY
        req_vld      = '0;
        uart_cmd_rdy = 1'b0;
        n = 1;
        while (rsp_vld == '0 && n < 2*TIMEOUT) begin
            tick();
            n++;
        end
        check("t4_latency", 32'(n),        32'(TIMEOUT));
        check("t4_rspvld",  32'(rsp_vld),  32'b0010);
        check("t4_rsperr",  32'(rsp_err),  32'd1);
        check("t4_rspdata", 32'(rsp_data), 32'd0);
        tick();                                        // IDLE
        set_cmd(0, 16'h8001);
        tick();                                        // ISSUE, engine busy
        tick();
        tick();
        check("t4_hold_vld",   32'(uart_cmd_vld), 32'd1);
        check("t4_hold_cmd",   32'(uart_cmd_in),  32'h8001);
        check("t4_hold_rdy",   32'(req_rdy),      32'd0);
        check("t4_hold_grant", 32'(grant_id),     32'd0);
        uart_cmd_rdy = 1'b1;
        #1;
        check("t4_accept", 32'(req_rdy), 32'b0001);
        tick();                                        // WAIT_BUSY
        req_vld      = '0;
        uart_cmd_rdy = 1'b0;
        tick();                                        // WAIT_DONE
        uart_cmd_rdy = 1'b1;
        tick();                                        // RESP
        check("t4_rsp2",    32'(rsp_vld), 32'b0001);
        check("t4_rsp2err", 32'(rsp_err), 32'd0);
        tick();

        // 6a: reset while in WAIT_DONE
        do_reset();
        set_cmd(0, 16'h8020);
        tick();                                        // ISSUE
        tick();                                        // WAIT_BUSY
        req_vld      = '0;
        uart_cmd_rdy = 1'b0;
        tick();                                        // WAIT_DONE
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("t6a");
        uart_cmd_rdy = 1'b1;
        seen = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen |= rsp_vld;
        end
        check("t6a_norsp", 32'(seen), 32'd0);

        // 6b: withdrawal in ISSUE while engine busy
        uart_cmd_rdy = 1'b0;
        set_cmd(0, 16'h8077);
        tick();                                        // ISSUE
        check("t6b_issue", 32'(uart_cmd_vld), 32'd1);
        seen = req_rdy;
        req_vld = '0;
        #1;
        seen |= req_rdy;
        tick();                                        // back to IDLE
        seen |= req_rdy | rsp_vld;
        check("t6b_nopulse", 32'(seen), 32'd0);
        check_idle_outputs("t6b");
        // Pointer untouched by the withdrawal: requester 0 still first.
        uart_cmd_rdy = 1'b1;
        set_cmd(0, 16'h8078);
        set_cmd(1, 16'h8079);
        txn("t6c", 0, 16'h8078, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        req_vld = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_cmd_arbiter.md
Name: uart_cmd_arbiter

Overview:
Round-robin arbiter and sequencer that shares one UART command engine among NUM_REQ requesters. It forwards one 16-bit command at a time, where bit 15 = 1 means write and bit 15 = 0 means read. It tracks the engine's busy/idle handshake until the transaction completes, then returns either a completion or read data to the requester that owns the grant. A timeout guards against a read that never answers.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CMD_WIDTH, 16, command width; bit CMD_WIDTH-1 is the R/W flag
READ_WIDTH, 8, read data width
TIMEOUT, 50000, maximum clk cycles from engine acceptance to completion
IDW, 2, grant index width; equals clog2(NUM_REQ)

Ports:
clk  in  1  single clock; all logic on posedge
rst  in  1  synchronous, active-high reset
req_vld  in  NUM_REQ  per-requester command valid
req_cmd  in  NUM_REQ*CMD_WIDTH  packed commands; requester i uses slice [i*CMD_WIDTH +: CMD_WIDTH]
req_rdy  out  NUM_REQ  one-hot pulse: command of requester i accepted by engine
rsp_vld  out  NUM_REQ  one-hot pulse: transaction of requester i finished
rsp_data  out  READ_WIDTH  read data; valid only with rsp_vld
rsp_err  out  1  timeout, or read finished without data; valid only with rsp_vld
busy  out  1  high in every state except IDLE
grant_id  out  IDW  index of current or last granted requester
uart_cmd_in  out  CMD_WIDTH  command to engine
uart_cmd_vld  out  1  command valid to engine
uart_cmd_rdy  in  1  engine idle / ready
uart_read_rdy  in  1  engine read-data pulse
uart_read_data  in  READ_WIDTH  engine read data

Behaviour:
- Reset values: all outputs 0. State IDLE, round-robin pointer last = NUM_REQ-1 (requester 0 has first priority), timeout counter 0. Reset asserted mid-transaction aborts immediately with no rsp_vld; the engine is not touched.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE: if any req_vld is high, grant the first set bit searching last+1, last+2, ... modulo NUM_REQ. Register grant_id and cmd_reg = req_cmd[grant], then go to ISSUE. With no request, stay in IDLE.
- ISSUE: uart_cmd_vld = 1 and uart_cmd_in = cmd_reg.
  - Accept condition: uart_cmd_vld && uart_cmd_rdy in the same cycle.
  - On accept: req_rdy[grant_id] pulses in that cycle, last <= grant_id, go to WAIT_BUSY.
  - If req_vld[grant_id] drops before accept: go to IDLE with no req_rdy and no rsp_vld; last is unchanged.
- WAIT_BUSY: uart_cmd_vld = 0. Wait for uart_cmd_rdy = 0, then go to WAIT_DONE.
- WAIT_DONE:
  - When uart_read_rdy = 1: rd_reg <= uart_read_data and got_rd <= 1. A second pulse overwrites rd_reg.
  - When uart_cmd_rdy = 1: go to RESP.
- Timeout counter:
  - Clears on accept and increments in WAIT_BUSY and WAIT_DONE.
  - At TIMEOUT-1 it forces RESP with err = 1.
  - If completion and timeout hit in the same cycle, completion wins (err = 0).
- RESP (exactly 1 cycle): rsp_vld[grant_id] = 1.
  - Read command: rsp_data = rd_reg and rsp_err = ~got_rd | timeout.
  - Write command: rsp_data = 0 and rsp_err = timeout.
  - Then clear got_rd and go to IDLE.
- Latency, request seen in IDLE at cycle N with an idle engine: uart_cmd_vld and req_rdy both appear at N+1. The earliest next grant is the cycle after RESP.
- Requester rules: req_cmd must be held stable while req_vld is high and until req_rdy. A new request from the same requester is allowed after its rsp_vld.
- Only one transaction is outstanding at a time. No output pulse lasts more than 1 cycle.

Test Plan:
1. Reset, then req_vld = 4'b0001 with cmd = 16'h8A55 and the engine model idle. Required: uart_cmd_in = 16'h8A55 and req_rdy = 4'b0001 one cycle after the request. After the engine's busy→idle, rsp_vld = 4'b0001 with rsp_err = 0 and rsp_data = 0.
2. Read: req 2 issues cmd = 16'h0031 and the engine model returns read_rdy with data 8'hC3. Required: rsp_vld = 4'b0100, rsp_data = 8'hC3, rsp_err = 0, grant_id = 2.
3. All four requesters hold req_vld continuously. Required: grant order 0, 1, 2, 3, 0 with exactly one req_rdy and one rsp_vld per transaction.
4. Read timeout: TIMEOUT = 100 and the engine stays busy. Required: rsp_vld 100 cycles after accept with rsp_err = 1, then the next request waits in ISSUE until uart_cmd_rdy = 1.
5. Read whose engine returns idle with no read_rdy. Required: rsp_err = 1, rsp_data = 0.
6. Reset asserted in WAIT_DONE, and separately req_vld dropped in ISSUE while uart_cmd_rdy = 0. Required: both return to IDLE with all outputs 0 and no rsp_vld. The withdrawal case additionally shows no req_rdy.
